// File: rtl/stopwatch_input_conditioner.sv
// Stopwatch input front end: 2-flop sync, tick-gated debounce, press pulses and pause state on clk_100MHz.
// Optional macro COND_PAUSE_TOGGLE_EN builds the pause toggle FSM; otherwise pause_state follows the held pause button.
module stopwatch_input_conditioner #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned STABLE_N = 4
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic btn_reset_raw,
    input  logic btn_pause_raw,
    input  logic sw_adj_raw,
    input  logic sw_sel_raw,
    output logic sample_tick,
    output logic reset_pulse,
    output logic pause_pulse,
    output logic pause_state,
    output logic adj,
    output logic sel
);

    localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MC_W    = 4;
    localparam int unsigned N_IN    = 4;
    localparam int unsigned IDX_RST = 0;
    localparam int unsigned IDX_PAU = 1;
    localparam int unsigned IDX_ADJ = 2;
    localparam int unsigned IDX_SEL = 3;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(TICK_DIV - 2);
    localparam logic [MC_W-1:0]  MC_STABLE = MC_W'(STABLE_N);

    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  sync1;
    logic [N_IN-1:0]  sync2;
    logic [N_IN-1:0]  lvl;
    logic [CNT_W-1:0] cnt;
    logic             rst_lvl_d;
    logic             pause_lvl_d;

    assign raw[IDX_RST] = btn_reset_raw;
    assign raw[IDX_PAU] = btn_pause_raw;
    assign raw[IDX_ADJ] = sw_adj_raw;
    assign raw[IDX_SEL] = sw_sel_raw;

    // Two-flop synchronizer for all raw inputs
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Sample tick: registered so it is high exactly while cnt == TICK_DIV-1
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            sample_tick <= (cnt == CNT_PRE);
        end
    end

    // One debouncer per input; a level is accepted after STABLE_N consecutive mismatching samples
    for (genvar g = 0; g < N_IN; g++) begin : g_deb
        logic            lvl_q;
        logic [MC_W-1:0] mc;
        logic [MC_W-1:0] mc_inc;

        assign mc_inc = mc + MC_W'(1);

        always_ff @(posedge clk_100MHz or negedge reset_n) begin
            if (!reset_n) begin
                lvl_q <= 1'b0;
                mc    <= '0;
            end else if (sample_tick) begin
                if (sync2[g] == lvl_q) begin
                    mc <= '0;
                end else if (mc_inc == MC_STABLE) begin
                    lvl_q <= sync2[g];
                    mc    <= '0;
                end else begin
                    mc <= mc_inc;
                end
            end
        end

        assign lvl[g] = lvl_q;
    end

    // Rising-edge pulses one cycle after the accepted level rises
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rst_lvl_d   <= 1'b0;
            pause_lvl_d <= 1'b0;
            reset_pulse <= 1'b0;
            pause_pulse <= 1'b0;
        end else begin
            rst_lvl_d   <= lvl[IDX_RST];
            pause_lvl_d <= lvl[IDX_PAU];
            reset_pulse <= lvl[IDX_RST] & ~rst_lvl_d;
            pause_pulse <= lvl[IDX_PAU] & ~pause_lvl_d;
        end
    end

    assign adj = lvl[IDX_ADJ];
    assign sel = lvl[IDX_SEL];

`ifdef COND_PAUSE_TOGGLE_EN
    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } pause_st_t;

    pause_st_t state;

    // Reset press wins over a simultaneous pause press; ADJ mode freezes the state
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else if (reset_pulse) begin
            state <= RUN;
        end else if (pause_pulse && !adj) begin
            state <= (state == RUN) ? PAUSED : RUN;
        end
    end

    assign pause_state = (state == PAUSED);
`else
    assign pause_state = lvl[IDX_PAU];
`endif

endmodule

// File: tb/tb_stopwatch_input_conditioner.sv
// Directed self-checking bench for stopwatch_input_conditioner with TICK_DIV=4, STABLE_N=3.
// Expected pause_state values follow COND_PAUSE_TOGGLE_EN as seen by this file.
`timescale 1ns/1ps
module tb_stopwatch_input_conditioner;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned STABLE_N = 3;
`ifdef COND_PAUSE_TOGGLE_EN
    localparam bit TOGGLE = 1'b1;
`else
    localparam bit TOGGLE = 1'b0;
`endif

    logic clk_100MHz;
    logic reset_n;
    logic btn_reset_raw;
    logic btn_pause_raw;
    logic sw_adj_raw;
    logic sw_sel_raw;
    logic sample_tick;
    logic reset_pulse;
    logic pause_pulse;
    logic pause_state;
    logic adj;
    logic sel;

    int checks;
    int errors;
    int ecnt;

    stopwatch_input_conditioner #(
        .TICK_DIV (TICK_DIV),
        .STABLE_N (STABLE_N)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .reset_n       (reset_n),
        .btn_reset_raw (btn_reset_raw),
        .btn_pause_raw (btn_pause_raw),
        .sw_adj_raw    (sw_adj_raw),
        .sw_sel_raw    (sw_sel_raw),
        .sample_tick   (sample_tick),
        .reset_pulse   (reset_pulse),
        .pause_pulse   (pause_pulse),
        .pause_state   (pause_state),
        .adj           (adj),
        .sel           (sel)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    // Advance one clock; ecnt counts rising edges since the last reset release
    task automatic cyc();
        @(posedge clk_100MHz);
        ecnt++;
        #1;
    endtask

    task automatic align4();
        while (ecnt % 4 != 0) cyc();
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        reset_n = 1'b0;
        btn_reset_raw = 1'b0;
        btn_pause_raw = 1'b0;
        sw_adj_raw = 1'b0;
        sw_sel_raw = 1'b0;
        repeat (3) cyc();
        outs = {sample_tick, reset_pulse, pause_pulse, pause_state, adj, sel};
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b expected 000000", outs);
        end
        reset_n = 1'b1;
        ecnt = 0;
    endtask

    task automatic test_tick_idle();
        logic exp_tick;
        logic [4:0] outs;
        for (int i = 0; i < 40; i++) begin
            cyc();
            exp_tick = (ecnt % 4 == 3);
            checks++;
            if (sample_tick !== exp_tick) begin
                errors++;
                $display("FAIL tick_cycle%0d: got %b expected %b", ecnt, sample_tick, exp_tick);
            end
            outs = {reset_pulse, pause_pulse, pause_state, adj, sel};
            checks++;
            if (outs !== 5'b0) begin
                errors++;
                $display("FAIL idle_outs_cycle%0d: got %b expected 00000", ecnt, outs);
            end
        end
    endtask

    task automatic test_pause_press();
        int pp;
        align4();
        btn_pause_raw = 1'b1;
        pp = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (pause_pulse) pp++;
        end
        checks++;
        if (pp !== 0) begin
            errors++;
            $display("FAIL pause_early: got %0d pulses expected 0", pp);
        end
        cyc();
        checks++;
        if (pause_pulse !== 1'b1) begin
            errors++;
            $display("FAIL pause_pulse_at13: got %b expected 1", pause_pulse);
        end
        checks++;
        if (pause_state !== (TOGGLE ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL pause_state_at13: got %b expected %b", pause_state, TOGGLE ? 1'b0 : 1'b1);
        end
        cyc();
        checks++;
        if ({pause_pulse, pause_state} !== 2'b01) begin
            errors++;
            $display("FAIL pause_at14: got pulse,state=%b expected 01", {pause_pulse, pause_state});
        end
        pp = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (pause_pulse) pp++;
        end
        checks++;
        if (pp !== 0 || pause_state !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold: got pulses=%0d state=%b expected 0 1", pp, pause_state);
        end
        btn_pause_raw = 1'b0;
        pp = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (pause_pulse) pp++;
        end
        checks++;
        if (pp !== 0 || pause_state !== TOGGLE) begin
            errors++;
            $display("FAIL pause_release: got pulses=%0d state=%b expected 0 %b", pp, pause_state, TOGGLE);
        end
        align4();
        btn_pause_raw = 1'b1;
        pp = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (pause_pulse) pp++;
        end
        checks++;
        if (pp !== 1 || pause_state !== ~TOGGLE) begin
            errors++;
            $display("FAIL pause_second: got pulses=%0d state=%b expected 1 %b", pp, pause_state, ~TOGGLE);
        end
        btn_pause_raw = 1'b0;
        repeat (16) cyc();
        checks++;
        if (pause_state !== 1'b0) begin
            errors++;
            $display("FAIL pause_second_release: got %b expected 0", pause_state);
        end
    endtask

    task automatic test_bounce();
        int pp;
        int st;
        pp = 0;
        st = 0;
        for (int k = 0; k < 12; k++) begin
            btn_pause_raw = (k % 2 == 0);
            for (int j = 0; j < 5; j++) begin
                cyc();
                if (pause_pulse) pp++;
                if (pause_state) st++;
            end
        end
        btn_pause_raw = 1'b0;
        for (int j = 0; j < 16; j++) begin
            cyc();
            if (pause_pulse) pp++;
            if (pause_state) st++;
        end
        checks++;
        if (pp !== 0) begin
            errors++;
            $display("FAIL bounce_pulse: got %0d pulses expected 0", pp);
        end
        checks++;
        if (st !== 0) begin
            errors++;
            $display("FAIL bounce_state: got %0d paused cycles expected 0", st);
        end
    endtask

    // Both buttons qualify on the same tick, from a given starting state
    task automatic both_press(input logic start_state, input string tag);
        int n;
        align4();
        btn_reset_raw = 1'b1;
        btn_pause_raw = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (reset_pulse || pause_pulse) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL %s_early: got %0d pulse cycles expected 0", tag, n);
        end
        cyc();
        checks++;
        if ({reset_pulse, pause_pulse} !== 2'b11) begin
            errors++;
            $display("FAIL %s_pulses: got rst,pause=%b expected 11", tag, {reset_pulse, pause_pulse});
        end
        cyc();
        checks++;
        if (pause_state !== (TOGGLE ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL %s_state: got %b expected %b (start %b)", tag, pause_state, TOGGLE ? 1'b0 : 1'b1, start_state);
        end
        btn_reset_raw = 1'b0;
        btn_pause_raw = 1'b0;
        repeat (16) cyc();
    endtask

    task automatic test_reset_priority();
        align4();
        btn_pause_raw = 1'b1;
        repeat (14) cyc();
        btn_pause_raw = 1'b0;
        repeat (16) cyc();
        checks++;
        if (pause_state !== TOGGLE) begin
            errors++;
            $display("FAIL prio_setup: got %b expected %b", pause_state, TOGGLE);
        end
        both_press(TOGGLE, "prio_paused");
        both_press(1'b0, "prio_run");
        checks++;
        if (pause_state !== 1'b0) begin
            errors++;
            $display("FAIL prio_end: got %b expected 0", pause_state);
        end
    endtask

    task automatic test_adj_sel();
        int rp;
        rp = 0;
        align4();
        sw_adj_raw = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cyc();
            if (reset_pulse) rp++;
        end
        checks++;
        if (adj !== 1'b0) begin
            errors++;
            $display("FAIL adj_early: got %b expected 0", adj);
        end
        cyc();
        checks++;
        if (adj !== 1'b1) begin
            errors++;
            $display("FAIL adj_accept: got %b expected 1", adj);
        end
        align4();
        btn_pause_raw = 1'b1;
        repeat (13) cyc();
        checks++;
        if (pause_pulse !== 1'b1) begin
            errors++;
            $display("FAIL adj_pause_pulse: got %b expected 1", pause_pulse);
        end
        cyc();
        checks++;
        if (pause_state !== ~TOGGLE) begin
            errors++;
            $display("FAIL adj_gate: got %b expected %b", pause_state, ~TOGGLE);
        end
        btn_pause_raw = 1'b0;
        repeat (16) cyc();
        align4();
        sw_sel_raw = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cyc();
            if (reset_pulse) rp++;
        end
        checks++;
        if (sel !== 1'b0) begin
            errors++;
            $display("FAIL sel_early: got %b expected 0", sel);
        end
        cyc();
        checks++;
        if (sel !== 1'b1) begin
            errors++;
            $display("FAIL sel_accept: got %b expected 1", sel);
        end
        sw_adj_raw = 1'b0;
        sw_sel_raw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (reset_pulse) rp++;
        end
        checks++;
        if ({adj, sel, pause_state} !== 3'b000 || rp !== 0) begin
            errors++;
            $display("FAIL switch_release: got adj,sel,state=%b rst_pulses=%0d expected 000 0", {adj, sel, pause_state}, rp);
        end
    endtask

    task automatic test_mid_reset();
        int pp;
        logic [5:0] outs;
        align4();
        btn_pause_raw = 1'b1;
        repeat (11) cyc();
        reset_n = 1'b0;
        #1;
        outs = {sample_tick, reset_pulse, pause_pulse, pause_state, adj, sel};
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL midrst_outs: got %b expected 000000", outs);
        end
        repeat (2) cyc();
        reset_n = 1'b1;
        ecnt = 0;
        pp = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (pause_pulse) pp++;
        end
        checks++;
        if (pp !== 0) begin
            errors++;
            $display("FAIL midrst_requal_early: got %0d pulses expected 0", pp);
        end
        cyc();
        checks++;
        if (pause_pulse !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pulse: got %b expected 1", pause_pulse);
        end
        cyc();
        checks++;
        if ({pause_pulse, pause_state} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_state: got pulse,state=%b expected 01", {pause_pulse, pause_state});
        end
        btn_pause_raw = 1'b0;
        repeat (16) cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ecnt = 0;
        test_reset();
        test_tick_idle();
        test_pause_press();
        test_bounce();
        test_reset_priority();
        test_adj_sel();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_input_conditioner.md
# stopwatch_input_conditioner

- Single-clock front end for the stopwatch. It synchronizes and debounces the raw reset and pause push buttons and the ADJ/SEL slider switches.
- It produces one-cycle press pulses, a pause state register and clean switch levels, all in the `clk_100MHz` domain.
- It sits directly upstream of the stopwatch counter and display logic and replaces per-button debouncers clocked by derived clocks.
- Everything runs on `clk_100MHz` gated by an internal sample tick, so no derived clocks are generated.

## Interface

Parameters:
- `TICK_DIV`, default 500000: sample-tick period in `clk_100MHz` cycles (range 2..2^20). 500000 gives 200 Hz.
- `STABLE_N`, default 4: number of consecutive equal samples required to accept a new level (range 2..15).

Ports:
- `clk_100MHz` input 1: master clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `btn_reset_raw` input 1: raw reset push button, active high.
- `btn_pause_raw` input 1: raw pause push button, active high.
- `sw_adj_raw` input 1: raw ADJ slider.
- `sw_sel_raw` input 1: raw SEL slider.
- `sample_tick` output 1: one-cycle strobe every `TICK_DIV` cycles.
- `reset_pulse` output 1: one-cycle pulse on an accepted reset press.
- `pause_pulse` output 1: one-cycle pulse on an accepted pause press.
- `pause_state` output 1: 1 = stopwatch paused.
- `adj` output 1: debounced ADJ level.
- `sel` output 1: debounced SEL level.

## Operation

- **Synchronizer:** each raw input passes through a 2-flop synchronizer. Synchronizer flops reset to 0.
- **Tick counter:** counts 0..`TICK_DIV`-1 and wraps. `sample_tick` = 1 in the cycle the counter equals `TICK_DIV`-1.
- **Per-input debouncer** (four identical instances). Each holds an accepted level `lvl` and a 4-bit match counter `mc`. On each `sample_tick`:
  - If the synchronized input equals `lvl`, `mc` ← 0.
  - Otherwise `mc` ← `mc`+1.
  - When `mc`+1 = `STABLE_N`, `lvl` ← the input and `mc` ← 0.
  - `mc` never exceeds `STABLE_N`-1.
  - Between ticks the debouncer holds its state.
- **Edge detect:**
  - `reset_pulse` = 1 for exactly one cycle when the reset debouncer `lvl` goes 0→1.
  - `pause_pulse` does the same for the pause debouncer.
  - Release (1→0) produces no pulse.
- **Pause state machine:** two states, RUN (`pause_state`=0) and PAUSED (`pause_state`=1).
  - `pause_pulse` in RUN → PAUSED.
  - `pause_pulse` in PAUSED → RUN.
  - `reset_pulse` → RUN, with priority over `pause_pulse` when both occur in the same cycle.
  - While `adj`=1, `pause_pulse` is ignored and the state holds.
- **Switch outputs:** `adj` and `sel` are the debouncer `lvl` values for the switches.

## Timing

- **Reset values** (all outputs and internal registers):
  - `sample_tick`=0, `reset_pulse`=0, `pause_pulse`=0, `pause_state`=0, `adj`=0, `sel`=0.
  - Tick counter = 0, all `lvl`=0, all `mc`=0.
- **Reset timing:** reset asserts asynchronously. Deassertion is sampled on the next `clk_100MHz` rising edge. The first `sample_tick` occurs `TICK_DIV` cycles after deassertion.
- **Acceptance latency:** a clean input change is accepted on the `STABLE_N`-th `sample_tick` after it leaves the synchronizer (2 cycles). `lvl` updates on the clock edge at that tick.
- **Pulse timing:** `reset_pulse` / `pause_pulse` assert in the cycle after `lvl` changes. `pause_state` toggles in the cycle after `pause_pulse`.
- **Bounce rejection:** any mismatch run shorter than `STABLE_N` ticks that is followed by a matching sample clears `mc` and produces no change.
- **Reset mid-operation:** `reset_n` low at any point clears all state immediately, including partial `mc` counts. A held button must be re-qualified after release.

## Configuration

- Macro: `COND_PAUSE_TOGGLE_EN`.
- **Defined:** `pause_state` behaves as the toggle state machine described above.
- **Undefined:**
  - The state machine is not built.
  - `pause_state` = the debounced pause `lvl` (the button must be held to pause).
  - `pause_pulse` is still generated.
  - `reset_pulse` has no effect on `pause_state`.

## Test plan

Bench parameters: `TICK_DIV`=4, `STABLE_N`=3, `COND_PAUSE_TOGGLE_EN` defined.

1. Release reset, idle 40 cycles → `sample_tick` high exactly at cycles 4, 8, 12, …; all other outputs remain 0.
2. `btn_pause_raw` 0→1 and held → exactly one `pause_pulse` and `pause_state` 0→1 at the 3rd tick after the sync delay. A second press-and-release → `pause_state` back to 0.
3. `btn_pause_raw` toggled every 5 cycles for 60 cycles (never stable for 3 ticks) → no `pause_pulse`; `pause_state` stays 0.
4. `pause_state`=1, then reset and pause buttons qualified in the same tick → single `reset_pulse` and `pause_pulse` in the same cycle; `pause_state`=0.
5. `sw_adj_raw`=1 is accepted, then a pause press → `pause_pulse` fires, `pause_state` unchanged. `sw_sel_raw` 0→1 → `sel`=1 after 3 ticks.
6. `reset_n` pulsed low while `mc`=2 on the pause debouncer → all outputs 0. Pause button still held after reset → it needs a full 3 new ticks before `pause_pulse`.
